// File: rtl/dp_arb_pkg.sv
// dp_arb_pkg: shared FSM states and default sizing for the job arbiter family
package dp_arb_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RELEASE} state_t;
  localparam int NREQ_DEF = 4;
  localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/dp_job_arbiter_rr_select.sv
// rr_select: picks the first set request at or after ptr, wrapping modulo N
module rr_select
  import dp_arb_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] owner
);
  // scan downward so the smallest offset from ptr is the last, winning write
  always_comb begin
    valid = |req;
    owner = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) owner = PW'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/dp_job_arbiter.sv
// dp_job_arbiter: round-robin sharing of one start/complete datapath with timeout
module dp_job_arbiter
  import dp_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] req_done,
  output logic            req_err,
  output logic            dp_start,
  input  logic            dp_complete,
  output logic            busy,
  output logic            err_sticky,
  input  logic            err_clr
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  state_t state, next;
  logic [PW-1:0] ptr, owner, sel;
  logic [CW-1:0] wait_cnt;
  logic [NREQ-1:0] owner_hot;
  logic sel_valid, err, expire;
  rr_select #(.N(NREQ)) u_sel (.req(req), .ptr(ptr), .valid(sel_valid), .owner(sel));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // next state and Moore output decode from state and registered owner
  always_comb begin
    expire = wait_cnt == CW'(TIMEOUT - 1);
    owner_hot = NREQ'(1) << owner;
    next = state == IDLE ? (sel_valid ? LAUNCH : IDLE) :
           state == LAUNCH ? WAIT :
           state == WAIT ? ((dp_complete || expire) ? RELEASE : WAIT) : IDLE;
    grant = state == IDLE ? '0 : owner_hot;
    req_done = state == RELEASE ? owner_hot : '0;
    req_err = state == RELEASE && err;
    dp_start = state == LAUNCH;
    busy = state != IDLE;
  end
  // owner capture, timeout counting, rotation pointer and sticky error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      owner <= '0;
      wait_cnt <= '0;
      err <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (state == IDLE && sel_valid) owner <= sel;
      if (state == LAUNCH) wait_cnt <= '0;
      else if (state == WAIT && !dp_complete && !expire) wait_cnt <= wait_cnt + 1'b1;
      if (state == LAUNCH) err <= 1'b0;
      else if (state == WAIT) err <= !dp_complete && expire;
      if (state == RELEASE) ptr <= owner == PW'(NREQ - 1) ? '0 : owner + 1'b1;
      err_sticky <= (state == RELEASE && err) ? 1'b1 : err_clr ? 1'b0 : err_sticky;
    end
endmodule

// File: doc/dp_job_arbiter.md
# dp_job_arbiter

Round-robin scheduler that shares one start/complete datapath among NREQ requesters. It sits between the requesting blocks and the datapath controller. It picks one pending requester, pulses the datapath start, and waits for complete or a timeout. It then returns a one-cycle done (with an error flag) to the granted requester. Only one job is in flight at a time.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 64: maximum number of WAIT cycles before a job is aborted; must be ≥ 2.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester job request; level, held by the requester until its done.
- grant  output  NREQ  one-hot owner of the datapath; 0 when idle.
- req_done  output  NREQ  one-cycle pulse to the owner when its job ends.
- req_err  output  1  high with req_done when the job ended by timeout.
- dp_start  output  1  one-cycle start pulse to the datapath controller.
- dp_complete  input  1  datapath finished; level or pulse, sampled only in WAIT.
- busy  output  1  high in every state except IDLE.
- err_sticky  output  1  set by any timeout; cleared only by err_clr or rst.
- err_clr  input  1  synchronous clear of err_sticky.

## Operation
- State machine IDLE, LAUNCH, WAIT, RELEASE. All outputs are Moore outputs decoded from registered state plus the registered owner index.
- IDLE: req is sampled only here. If any bit is set, the owner is the first set bit at or after ptr, scanning upward with wrap modulo NREQ. The owner index is registered and the next state is LAUNCH. With no requests, stay in IDLE.
- LAUNCH: dp_start=1 and grant=onehot(owner). Clear wait_cnt to 0. Next state is WAIT unconditionally; dp_complete is ignored in this state.
- WAIT: grant stays held.
  - If dp_complete=1, go to RELEASE with err=0.
  - Else if wait_cnt==TIMEOUT-1, go to RELEASE with err=1.
  - Else increment wait_cnt.
  - If complete and timeout coincide, complete wins and err=0.
- RELEASE:
  - req_done[owner]=1 and req_err=err; grant stays held.
  - err_sticky is set if err=1; a set has priority over an err_clr in the same cycle.
  - ptr becomes (owner+1) mod NREQ. Next state is IDLE.
- A requester dropping req after it is granted does not abort the job; done still pulses.
- wait_cnt width is $clog2(TIMEOUT). ptr width is $clog2(NREQ).
- Reset values:
  - state=IDLE, ptr=0, owner=0, wait_cnt=0, err=0.
  - grant=0, req_done=0, req_err=0, dp_start=0, busy=0, err_sticky=0.
- Reset mid-job returns to IDLE at once. No done is issued, and the datapath is expected to be reset by the same rst.

## Timing
- req sampled at edge k (state IDLE): LAUNCH and grant are visible after edge k, and dp_start is high for exactly the cycle between edges k and k+1.
- dp_complete high in the n-th WAIT cycle (n=1 is the first): req_done is high during the next cycle.
- Request-to-done latency is n+2 cycles, counted from the cycle after sampling.
- Timeout: with no complete, req_done asserts after TIMEOUT WAIT cycles.
- Back-to-back jobs: RELEASE to IDLE to LAUNCH. There is a minimum of one IDLE cycle between done and the next dp_start.

## Structure
- Shared package dp_arb_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT, RELEASE);
  - the default NREQ and TIMEOUT constants.
- Sub-module rr_select (combinational):
  - inputs are the req vector and ptr;
  - outputs are valid and the owner index;
  - it is reused by any future multi-requester scheduler.
- The top holds the FSM, owner/ptr/wait_cnt/err registers and output decode.

## Test plan
- Reset, then req=0100 held:
  - grant=0100 and dp_start pulses once;
  - complete in the 3rd WAIT cycle gives req_done=0100 for one cycle with req_err=0;
  - ptr=3 afterwards.
- req=1111 held throughout with a prompt complete each job: grants 0001, 0010, 0100, 1000, 0001 in order, each separated by a done.
- TIMEOUT=16 and no complete:
  - req_done and req_err pulse after exactly 16 WAIT cycles, and err_sticky=1;
  - an err_clr pulse returns err_sticky to 0.
- dp_complete asserted on the same cycle wait_cnt==TIMEOUT-1: done with req_err=0 and err_sticky unchanged. Also, dp_complete high during LAUNCH is ignored.
- rst asserted mid-WAIT: all outputs go to 0 asynchronously; after release, req=0010 is granted via ptr=0 scanning.
- Owner drops req during WAIT: the job completes and req_done still pulses for that owner.
